// File: rtl/wisc_pkg.sv
// Shared opcode constants, decode helpers and commit-state
// encoding for the ALU writeback/commit slice.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_PADDSB = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_RED    = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  function automatic logic writes_reg(
    input logic [3:0] op
  );
    logic w;
    unique case (1'b1)
      !op[3]:       w = 1'b1;
      op == OP_LLB: w = 1'b1;
      op == OP_LHB: w = 1'b1;
      op == OP_PCS: w = 1'b1;
      default:      w = 1'b0;
    endcase
    return w;
  endfunction

  // Enables ordered {Z, V, N}
  function automatic logic [2:0] flag_mask(
    input logic [3:0] op
  );
    logic [2:0] m;
    unique case (1'b1)
      op == OP_ADD: m = 3'b111;
      op == OP_SUB: m = 3'b111;
      op == OP_XOR: m = 3'b100;
      op == OP_SLL: m = 3'b100;
      op == OP_SRA: m = 3'b100;
      op == OP_ROR: m = 3'b100;
      default:      m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// In-order result buffer between ALU handshake and
// register-file write port; head is read combinationally.
module alu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_commit.sv
// Writeback/commit stage: buffers ALU results, drains them to
// the register file, commits flags in order and halts on HLT.
module alu_commit
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_Z,
  input  logic              in_V,
  input  logic              in_N,
  input  logic [3:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              flag_Z,
  output logic              flag_V,
  output logic              flag_N,
  output logic              halted,
  output logic              busy
);

  localparam int EW = DATA_W + 3 + 4 + REG_AW;
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q;
  logic [2:0]        flags_q, flags_d;
  logic [EW-1:0]     head;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic              accept, pop, head_wr;
  logic [DATA_W-1:0] h_data;
  logic              h_z, h_v, h_n;
  logic [3:0]        h_op;
  logic [REG_AW-1:0] h_rd;
  logic [2:0]        h_mask;

  assign in_ready = (state_q == RUN) && !full && rst;
  assign accept   = in_valid && in_ready;

  alu_wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (accept),
    .din_i   ({in_data, in_Z, in_V, in_N, in_opcode, in_rd}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign {h_data, h_z, h_v, h_n, h_op, h_rd} = head;
  assign h_mask = flag_mask(h_op);

  // rd == 0 turns any writing opcode into a pass-through commit
  assign head_wr = !empty && writes_reg(h_op) && (h_rd != '0);
  assign pop     = !empty && (!head_wr || wr_ready);

  assign wr_en   = head_wr;
  assign wr_addr = head_wr ? h_rd : '0;
  assign wr_data = head_wr ? h_data : '0;
  assign busy    = count != '0;

  always_comb begin
    flags_d = flags_q;
    if (pop) begin
      if (h_mask[2]) flags_d[2] = h_z;
      if (h_mask[1]) flags_d[1] = h_v;
      if (h_mask[0]) flags_d[0] = h_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

  assign {flag_Z, flag_V, flag_N} = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      halted  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept && in_opcode == OP_HLT)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && h_op == OP_HLT) begin
            state_q <= HALTED;
            halted  <= 1'b1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_commit.sv
// Scoreboard bench for alu_commit: a queue model of the FIFO,
// flag register and halt state checked every cycle.
module tb_alu_commit;

  typedef struct packed {
    logic [15:0] d;
    logic        z, v, n;
    logic [3:0]  op;
    logic [3:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_Z = 1'b0, in_V = 1'b0, in_N = 1'b0;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_rd = '0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        flag_Z, flag_V, flag_N;
  logic        halted, busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t sb[$];
  logic mZ = 1'b0, mV = 1'b0, mN = 1'b0;
  int   mstate = 0;

  always #5 clk = ~clk;

  alu_commit #(
    .DATA_W (16),
    .REG_AW (4),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_Z      (in_Z),
    .in_V      (in_V),
    .in_N      (in_N),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flag_Z    (flag_Z),
    .flag_V    (flag_V),
    .flag_N    (flag_N),
    .halted    (halted),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit m_writes(input ent_t e);
    return (e.rd != 4'd0) &&
           (e.op inside {[4'd0:4'd7], 4'd10, 4'd11, 4'd14});
  endfunction

  function automatic logic [2:0] m_mask(input logic [3:0] op);
    case (op)
      4'd0, 4'd2:             return 3'b111;
      4'd3, 4'd4, 4'd5, 4'd6: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  always @(negedge clk) begin
    ent_t       h;
    ent_t       e;
    logic [2:0] m;
    if (!rst) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_flags", {flag_Z, flag_V, flag_N}, 0);
      check("rst_halted", halted, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      sb.delete();
      {mZ, mV, mN} = 3'b000;
      mstate = 0;
    end else begin
      check("flags", {flag_Z, flag_V, flag_N}, {mZ, mV, mN});
      check("busy", busy, sb.size() != 0);
      check("halted", halted, mstate == 2);
      check("in_ready", in_ready,
            (mstate == 0) && (sb.size() < 2));
      if (sb.size() != 0) begin
        h = sb[0];
        check("wr_en", wr_en, m_writes(h));
        if (m_writes(h)) begin
          check("wr_addr", wr_addr, h.rd);
          check("wr_data", wr_data, h.d);
        end
        if (!m_writes(h) || wr_ready) begin
          void'(sb.pop_front());
          m = m_mask(h.op);
          if (m[2]) mZ = h.z;
          if (m[1]) mV = h.v;
          if (m[0]) mN = h.n;
          if (h.op == 4'hF) mstate = 2;
        end
      end else begin
        check("wr_en_idle", wr_en, 0);
      end
      if (in_valid && in_ready) begin
        e = '{d: in_data, z: in_Z, v: in_V, n: in_N,
              op: in_opcode, rd: in_rd};
        sb.push_back(e);
        if (in_opcode == 4'hF) mstate = 1;
      end
    end
  end

  // Returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] op,
                      input logic [3:0] rd,
                      input logic [15:0] d,
                      input logic z, input logic v,
                      input logic n);
    in_opcode = op;
    in_rd     = rd;
    in_data   = d;
    {in_Z, in_V, in_N} = {z, v, n};
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    send(4'h0, 4'd3, 16'h0000, 1, 0, 0);
    check("add_wr_en", wr_en, 1);
    check("add_wr_addr", wr_addr, 3);
    check("add_wr_data", wr_data, 16'h0000);
    wait_idle();
    check("add_flags", {flag_Z, flag_V, flag_N}, 3'b100);

    send(4'h3, 4'd2, 16'h00F0, 0, 1, 1);
    wait_idle();
    check("xor_flags", {flag_Z, flag_V, flag_N}, 3'b000);
    send(4'h9, 4'd5, 16'h1234, 1, 1, 1);
    check("sw_no_wr", wr_en, 0);
    wait_idle();
    check("sw_flags", {flag_Z, flag_V, flag_N}, 3'b000);

    wr_ready = 1'b0;
    send(4'h0, 4'd5, 16'h1111, 0, 0, 0);
    send(4'h2, 4'd6, 16'h2222, 0, 0, 1);
    in_opcode = 4'h1;
    in_rd     = 4'd7;
    in_data   = 16'h3333;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", in_ready, 0);
      check("stall_addr", wr_addr, 5);
    end
    tick();
    wr_ready = 1'b1;
    send(4'h1, 4'd7, 16'h3333, 0, 0, 0);
    wait_idle();

    send(4'hA, 4'd0, 16'h5555, 0, 0, 0);
    check("llb_rd0_no_wr", wr_en, 0);
    @(posedge clk);
    @(negedge clk);
    check("llb_1cyc", busy, 0);
    tick();
    send(4'hE, 4'd15, 16'h0042, 0, 0, 0);
    check("pcs_wr_en", wr_en, 1);
    check("pcs_addr", wr_addr, 15);
    check("pcs_data", wr_data, 16'h0042);
    wait_idle();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(4'($urandom_range(0, 14)),
               4'($urandom_range(0, 15)),
               16'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          wr_ready = ($urandom_range(0, 3) != 0);
        end
        wr_ready = 1'b1;
      end
    join
    wait_idle();

    send(4'h0, 4'd1, 16'h0001, 0, 1, 0);
    send(4'hF, 4'd0, 16'h0000, 0, 0, 0);
    in_opcode = 4'h2;
    in_rd     = 4'd9;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hlt_refuse", in_ready, 0);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    check("halt_seen", halted, 1);
    repeat (4) begin
      @(negedge clk);
      check("halt_hold", halted, 1);
      check("halt_ready", in_ready, 0);
    end
    tick();
    rst = 1'b0;
    #1;
    check("halt_rst", halted, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("post_halt_ready", in_ready, 1);
    tick();

    send(4'h0, 4'd4, 16'hBEEF, 0, 1, 1);
    wait_idle();
    check("pre_rst_flags", {flag_Z, flag_V, flag_N}, 3'b011);
    wr_ready = 1'b0;
    send(4'h0, 4'd7, 16'h0007, 1, 1, 1);
    send(4'h2, 4'd8, 16'h0008, 1, 1, 1);
    @(negedge clk);
    check("pend_wr_en", wr_en, 1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flags", {flag_Z, flag_V, flag_N}, 0);
    tick();
    rst = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    check("rel_ready", in_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_wr_en", wr_en, 0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_commit.md
# alu_commit

Writeback and commit stage on the consumer side of the ALU result interface. It accepts one ALU result per handshake: result word, Z/V/N candidates, opcode and destination register. Results are buffered in a small in-order FIFO and drained into the register-file write port, which the load path can stall. The architectural flag register is updated only as each entry commits, and the block halts the datapath after an HLT commits.

## Interface
- DATA_W, 16, result/register width
- REG_AW, 4, register address width (16 registers)
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  ALU result valid
- in_ready  out  1  block can accept this cycle
- in_data  in  DATA_W  ALU result (byte-load merge already applied)
- in_Z, in_V, in_N  in  1 each  flag candidates from ALU
- in_opcode  in  4  instruction opcode
- in_rd  in  REG_AW  destination register
- wr_en  out  1  register-file write request
- wr_addr  out  REG_AW  write address
- wr_data  out  DATA_W  write data
- wr_ready  in  1  write port granted; low when the load path owns the port
- flag_Z, flag_V, flag_N  out  1 each  architectural flags
- halted  out  1  HLT has committed
- busy  out  1  FIFO non-empty

## Operation
- Accept when in_valid && in_ready; push {data, Z, V, N, opcode, rd} at the FIFO tail.
- Register-writing opcodes: 0000–0111, 1010, 1011, 1110. Any other opcode, or rd == 0, is a non-writing entry.
- Flag update mask: ADD 0000 and SUB 0010 update Z, V and N. XOR 0011, SLL 0100, SRA 0101 and ROR 0110 update Z only. All other opcodes leave the flags unchanged.
- Head commit:
  - A writing head commits when wr_ready = 1.
  - A non-writing head commits unconditionally in one cycle.
  - On commit, pop the head and apply the flag mask using the stored candidates.
- wr_en = head valid && writing entry; wr_addr and wr_data come from the head. wr_en stays asserted with stable address and data until wr_ready.
- State machine:
  - RUN: normal operation.
  - RUN → DRAIN on acceptance of HLT (1111). in_ready = 0 in DRAIN and HALTED.
  - DRAIN → HALTED when the HLT entry commits. Entries ahead of HLT commit normally.
  - HALTED: exited only by reset.
- in_ready = (state == RUN) && count < DEPTH && rst released. Push to a full FIFO cannot occur.
- Simultaneous push and pop: allowed whenever not full; count is unchanged and ordering is preserved.

## Timing
- Reset values (asynchronous, active-low):
  - FIFO empty, state RUN.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - flag_Z/V/N = 0, halted = 0, busy = 0.
  - in_ready = 0 while rst = 0.
- Latency: an entry accepted at edge k can drive wr_en in cycle k+1. Earliest flag update is visible after edge k+1.
- Flags change only on commit edges, never on accept.
- halted rises in the cycle after the HLT commit edge.
- wr_ready low for N cycles stalls the head N cycles. The FIFO fills and in_ready drops once DEPTH entries are held.
- Reset mid-operation discards all entries and any pending write immediately; no partial commit.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Structure
- Shared package wisc_pkg holds:
  - opcode constants (OP_ADD … OP_HLT);
  - functions writes_reg(opcode) and flag_mask(opcode) returning {Z, V, N} enables;
  - state enum {RUN, DRAIN, HALTED}.
- Sub-module alu_wb_fifo: synchronous FIFO parameterised by width and DEPTH, with push/pop/full/empty/count ports. The top level holds the FSM, commit logic and flag register.

## Test plan
- Reset, then ADD rd = 3, data 0x0000, Z = 1, N = 0, V = 0 with wr_ready = 1 → wr_en in the next cycle, wr_addr = 3, wr_data = 0x0000; after commit flag_Z = 1, flag_N = 0, flag_V = 0.
- XOR rd = 2, Z = 0, V = 1, N = 1 after prior flags Z = 1, V = 0, N = 0 → flag_Z = 0 while V stays 0 and N stays 0; SW (1001) with Z = 1 → no wr_en and flags unchanged.
- Hold wr_ready = 0 and push three writing entries → first two accepted, in_ready = 0 on the third. Release wr_ready → writes in order with no drops or duplicates.
- LLB rd = 0 → no wr_en and the entry commits in one cycle; PCS rd = 15, data 0x0042 → write 0x0042 to r15.
- Push ADD, HLT, then attempt SUB → SUB refused (in_ready = 0). ADD commits, then halted = 1 one cycle after HLT commits. HALTED persists until rst pulses low.
- Assert rst low with two entries pending and wr_en high → wr_en, busy and flags go to 0 immediately. After release, in_ready = 1 and the FIFO is empty.
